// File: rtl/morse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : morse_pkg                                                  |
// | Purpose : Shared constants and player state encoding for the Morse   |
// |           playback path (element/gap durations in Morse time units). |
// | Ports   : none (package)                                             |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package morse_pkg;

  localparam int MORSE_MAX_LEN = 40;
  localparam int MORSE_CODE_W  = 40;
  localparam int MORSE_LEN_W   = 6;

  // Durations in Morse time units; the interval counter is 3 bits wide.
  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MARK   = 3'd1,
    ST_ESPACE = 3'd2,
    ST_CGAP   = 3'd3,
    ST_DONE   = 3'd4
  } player_state_t;

  // A playable character has 1..MORSE_MAX_LEN elements (0 is a word space).
  function automatic logic len_is_char(input logic [MORSE_LEN_W-1:0] len);
    return (len != '0) && (len <= MORSE_LEN_W'(MORSE_MAX_LEN));
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_unit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : morse_unit_timer                                           |
// | Purpose : Measures an interval of 'units' Morse time units, each     |
// |           UNIT_CYCLES clocks long. expire is high on the last clock  |
// |           of the interval.                                           |
// | Ports   : clk, rst_n (async, active-low)                             |
// |           clear  - restart the interval from zero on the next edge   |
// |           units  - interval length in units (1..7)                   |
// |           expire - last cycle of the requested interval              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [2:0] units,
  output logic       expire
);

  localparam int UC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UC_W-1:0] C_UNIT_LAST = UC_W'(UNIT_CYCLES - 1);

  logic [UC_W-1:0] r_cycle_cnt;
  logic [2:0]      r_unit_cnt;
  logic            w_unit_end;

  assign w_unit_end = (r_cycle_cnt == C_UNIT_LAST);
  assign expire     = w_unit_end && (r_unit_cnt == (units - 3'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_unit_cnt  <= '0;
    end else if (clear) begin
      r_cycle_cnt <= '0;
      r_unit_cnt  <= '0;
    end else if (w_unit_end) begin
      r_cycle_cnt <= '0;
      r_unit_cnt  <= r_unit_cnt + 3'd1;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + UC_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/morse_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : morse_player                                               |
// | Purpose : Replays one encoded Morse character (or a word space) as a |
// |           timed keying signal plus a gated square-wave tone.         |
// | Ports   : clk, rst_n (async, active-low)                             |
// |           start, abort, code_in[39:0], len_in[5:0]   - request      |
// |           busy, done, error                          - status       |
// |           key_out, tone_out                          - playback     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module morse_player
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12500000,
  parameter int TONE_HALF   = 25000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [39:0] code_in,
  input  logic [5:0]  len_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        key_out,
  output logic        tone_out
);

  localparam int TH_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [TH_W-1:0] C_TONE_LAST = TH_W'(TONE_HALF - 1);

  player_state_t r_state, w_state_nxt;

  logic [MORSE_CODE_W-1:0] r_code;
  logic [MORSE_LEN_W-1:0]  r_idx;
  logic [2:0]              r_gap, w_gap_nxt;
  logic [TH_W-1:0]         r_tone_cnt;

  logic       w_start_ok;
  logic       w_latch;
  logic       w_idx_dec;
  logic       w_timer_clear;
  logic [2:0] w_timer_units;
  logic       w_expire;
  logic       w_busy_d, w_key_d, w_done_d, w_err_d;

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_timer_clear),
    .units  (w_timer_units),
    .expire (w_expire)
  );

  // A start arriving while the done pulse is still visible is not taken;
  // the next request is accepted from the cycle after done.
  assign w_start_ok = start && !abort && !done;

  always_comb begin
    w_state_nxt   = r_state;
    w_gap_nxt     = r_gap;
    w_latch       = 1'b0;
    w_idx_dec     = 1'b0;
    w_err_d       = 1'b0;
    w_timer_clear = 1'b0;
    w_timer_units = DOT_UNITS;

    unique case (r_state)
      ST_IDLE: begin
        w_timer_clear = 1'b1;
        if (w_start_ok) begin
          if (len_in == '0) begin
            w_state_nxt = ST_CGAP;
            w_gap_nxt   = WORD_GAP_UNITS;
          end else if (len_is_char(len_in)) begin
            w_state_nxt = ST_MARK;
            w_latch     = 1'b1;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      ST_MARK: begin
        w_timer_units = r_code[r_idx] ? DASH_UNITS : DOT_UNITS;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          if (r_idx == '0) begin
            w_state_nxt = ST_CGAP;
            w_gap_nxt   = CHAR_GAP_UNITS;
          end else begin
            w_state_nxt = ST_ESPACE;
            w_idx_dec   = 1'b1;
          end
        end
      end
      ST_ESPACE: begin
        w_timer_units = ELEM_GAP_UNITS;
        if (abort)         w_state_nxt = ST_IDLE;
        else if (w_expire) w_state_nxt = ST_MARK;
      end
      ST_CGAP: begin
        w_timer_units = r_gap;
        if (abort)         w_state_nxt = ST_IDLE;
        else if (w_expire) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Every state entry restarts the interval so each one is exact.
    if (w_state_nxt != r_state) w_timer_clear = 1'b1;

    // Status outputs follow the state one cycle later, except that abort
    // drops them together with the state.
    w_busy_d = ((r_state == ST_MARK) || (r_state == ST_ESPACE) ||
                (r_state == ST_CGAP)) && !abort;
    w_key_d  = (r_state == ST_MARK) && !abort;
    w_done_d = (r_state == ST_DONE) && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code  <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      key_out <= 1'b0;
    end else begin
      if (w_latch) begin
        r_code <= code_in;
        r_idx  <= len_in - 6'd1;
      end else if (w_idx_dec) begin
        r_idx  <= r_idx - 6'd1;
      end
      r_gap   <= w_gap_nxt;
      busy    <= w_busy_d;
      done    <= w_done_d;
      error   <= w_err_d;
      key_out <= w_key_d;
    end
  end

  // Tone divider: held at zero outside a mark, and also on the first mark
  // cycle so every mark starts with tone_out low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tone_cnt <= '0;
      tone_out   <= 1'b0;
    end else if (!w_key_d || !key_out) begin
      r_tone_cnt <= '0;
      tone_out   <= 1'b0;
    end else if (r_tone_cnt == C_TONE_LAST) begin
      r_tone_cnt <= '0;
      tone_out   <= ~tone_out;
    end else begin
      r_tone_cnt <= r_tone_cnt + TH_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_morse_player                                            |
// | Purpose : Scoreboard bench for morse_player (UNIT_CYCLES=4,          |
// |           TONE_HALF=2). Stimulus queues expected keying events; a    |
// |           monitor measures mark/space/busy run lengths and pulses.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_morse_player;

  localparam int UC = 4;
  localparam int TH = 2;

  localparam int K_MARK  = 0;  // val = mark length in cycles
  localparam int K_SPACE = 1;  // val = key-low length while busy
  localparam int K_END   = 2;  // val = busy length * 2 + done
  localparam int K_ERR   = 3;  // val = {busy, done, key_out} during error
  localparam int K_DONE  = 4;  // stray done pulse (never expected)

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [39:0] code_in = '0;
  logic [5:0]  len_in = '0;
  logic        busy, done, error, key_out, tone_out;

  morse_player #(
    .UNIT_CYCLES (UC),
    .TONE_HALF   (TH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .code_in  (code_in),
    .len_in   (len_in),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .key_out  (key_out),
    .tone_out (tone_out)
  );

  always #5 clk = ~clk;

  task automatic expect_ev(input int k, input int v);
    ev_t e;
    e.kind = 3'(k);
    e.val  = 32'(v);
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input int v);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got kind=%0d val=%0d, required no event (t=%0t)", k, v, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != 3'(k) || e.val != 32'(v)) begin
        n_bad++;
        $display("FAIL event: got kind=%0d val=%0d, required kind=%0d val=%0d (t=%0t)",
                 k, v, e.kind, e.val, $time);
      end
    end
  endtask

  task automatic check(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic pk, pb;
  int   nhi, nlo, nbusy;
  logic exp_t;

  always @(negedge clk) begin
    if (!rst_n) begin
      pk = 1'b0; pb = 1'b0; nhi = 0; nlo = 0; nbusy = 0;
    end else begin
      exp_t = key_out ? (((nhi / TH) % 2) == 1) : 1'b0;
      check("tone", tone_out, exp_t);
      if (key_out && !pk && nlo > 0) begin
        observe(K_SPACE, nlo);
        nlo = 0;
      end
      if (key_out) nhi++;
      if (pk && !key_out) begin
        observe(K_MARK, nhi);
        nhi = 0;
      end
      if (busy && !key_out) nlo++;
      if (busy) nbusy++;
      if (pb && !busy) begin
        if (nlo > 0) observe(K_SPACE, nlo);
        nlo = 0;
        observe(K_END, nbusy * 2 + (done ? 1 : 0));
        nbusy = 0;
      end else if (done) begin
        observe(K_DONE, 0);
      end
      if (error) observe(K_ERR, {busy, done, key_out});
      pk = key_out;
      pb = busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [39:0] c, input logic [5:0] l);
    @(posedge clk);
    #1 code_in = c; len_in = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done || error) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL timeout: got no done/error within %0d cycles, required one", limit);
    end
  endtask

  task automatic expect_e();
    expect_ev(K_MARK, 4);
    expect_ev(K_SPACE, 12);
    expect_ev(K_END, 16 * 2 + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_key", key_out, 1'b0);
    check("rst_tone", tone_out, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: "E"
    expect_e();
    send(40'd0, 6'd1);
    wait_end(100);

    // 2: "A" = dot dash
    expect_ev(K_MARK, 4);
    expect_ev(K_SPACE, 4);
    expect_ev(K_MARK, 12);
    expect_ev(K_SPACE, 12);
    expect_ev(K_END, 32 * 2 + 1);
    send(40'b01, 6'd2);
    wait_end(100);

    // 3: word space
    expect_ev(K_SPACE, 28);
    expect_ev(K_END, 28 * 2 + 1);
    send(40'd0, 6'd0);
    wait_end(100);

    // 4: "0" = five dashes, then the same code with an illegal length
    for (int i = 0; i < 5; i++) begin
      expect_ev(K_MARK, 12);
      if (i < 4) expect_ev(K_SPACE, 4);
    end
    expect_ev(K_SPACE, 12);
    expect_ev(K_END, 88 * 2 + 1);
    send(40'b11111, 6'd5);
    wait_end(200);

    expect_ev(K_ERR, 0);
    send(40'b11111, 6'd41);
    wait_end(20);
    repeat (5) @(posedge clk);

    // 5: "T" aborted six cycles into the dash
    expect_ev(K_MARK, 6);
    expect_ev(K_END, 6 * 2 + 0);
    send(40'd1, 6'd1);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    repeat (4) @(posedge clk);

    // start together with abort in IDLE: nothing starts, no error
    #1 code_in = 40'd0; len_in = 6'd1; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 len_in = 6'd41;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    repeat (5) @(posedge clk);

    expect_e();
    send(40'd0, 6'd1);
    wait_end(100);

    // 6: "M" requested in the middle of "E" is ignored
    expect_e();
    send(40'd0, 6'd1);
    repeat (5) @(posedge clk);
    #1 code_in = 40'b11; len_in = 6'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_end(100);
    repeat (2) @(posedge clk);

    // reset in the middle of a mark, with the tone already high
    send(40'd1, 6'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_key", key_out, 1'b0);
    check("midrst_tone", tone_out, 1'b0);
    check("midrst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_key", key_out, 1'b0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d unobserved events, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/morse_player.md
Name: morse_player

Overview:
Downstream stage of the Text→Morse translator. It accepts one encoded character (code, length) per start strobe and replays it as a timed on/off keying signal plus a gated square-wave tone for an LED or buzzer. Timing follows standard Morse unit ratios. It reports busy, a done pulse, and an error pulse for illegal lengths.

Parameters:
UNIT_CYCLES, 12500000, clk cycles per Morse time unit (250 ms at 50 MHz); must be ≥2.
TONE_HALF, 25000, clk cycles per tone half-period (1 kHz at 50 MHz); must be ≥1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request to play; sampled only in IDLE
abort  in  1  synchronous cancel; stops any play in progress
code_in  in  40  element bits; 0=dot, 1=dash; first element at bit len_in-1, last at bit 0
len_in  in  6  element count; 0=word space, 1..40 valid, 41..63 illegal
busy  out  1  high while a character or space is being played
done  out  1  one-cycle pulse on normal completion
error  out  1  one-cycle pulse when start is rejected
key_out  out  1  high during a mark (dot/dash)
tone_out  out  1  square wave at 1/(2·TONE_HALF) of clk when key_out=1, else 0

Behaviour:
- Reset: state=IDLE. busy, done, error, key_out, tone_out=0. Latched code, length and counters cleared. Reset mid-play takes effect immediately and nothing is resumed.
- All outputs are registered.
- States: IDLE, MARK, ESPACE (inter-element gap), CGAP (character/word gap), DONE.
- IDLE, start=1, abort=0:
  - len_in in 1..40: latch code and length; idx=len_in-1; next cycle MARK, busy=1, key_out=1.
  - len_in=0: next cycle CGAP with a 7-unit gap, busy=1, key_out stays 0.
  - len_in>40: error=1 for exactly one cycle; stay IDLE; busy, done and key_out stay 0.
- Latency: start sampled at edge k; busy and key_out rise after edge k+1.
- MARK: key_out=1 for 1 unit if code[idx]=0, or 3 units if code[idx]=1.
  - Then if idx=0, go to CGAP with a 3-unit gap.
  - Otherwise go to ESPACE for 1 unit, decrement idx, return to MARK.
- Unit timer restarts on every state entry, so each interval is exactly N·UNIT_CYCLES clk cycles.
- CGAP end → DONE. DONE lasts one cycle: done=1, busy=0, key_out=0. Then IDLE; a new start is accepted from the cycle after done.
- start while busy is ignored, with no error and no queuing. Inputs are latched, so changes to code_in/len_in during play have no effect.
- abort=1 in any non-IDLE state:
  - Next cycle state=IDLE; busy, key_out, tone_out=0.
  - done is not pulsed.
  - abort and start together in IDLE: abort wins, nothing starts, no error.
- Tone:
  - Divider counter is held at 0 while key_out=0.
  - While key_out=1 it counts 0..TONE_HALF-1 and toggles tone_out at wrap.
  - tone_out starts at 0 each mark and is forced to 0 as soon as key_out falls.
- Width rules:
  - idx is 6 bits.
  - Unit counter is wide enough for UNIT_CYCLES-1.
  - Interval counter is 3 bits (max 7 units).

Decomposition:
- Package morse_pkg:
  - MORSE_MAX_LEN=40, MORSE_CODE_W=40, MORSE_LEN_W=6.
  - DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7.
  - Player state encoding.
- Sub-module morse_unit_timer:
  - Inputs: clear, units (3-bit).
  - Counts UNIT_CYCLES per unit and pulses expire on the last cycle of the requested interval.
  - Instantiated once.
- Tone divider stays inline.

Test Plan (UNIT_CYCLES=4, TONE_HALF=2):
1. "E" (len=1, code=0) → key_out high 4 cycles, low 12 cycles; done pulses on the next cycle; busy high 16 cycles.
2. "A" (len=2, code=2'b01) → key_out pattern high 4 / low 4 / high 12 / low 12; done once; tone_out toggles every 2 cycles only while key_out=1.
3. Space (len=0) → key_out never high; busy high 28 cycles; then done.
4. "0" (len=5, code=5'b11111) → five 12-cycle marks separated by 4-cycle gaps, then a 12-cycle gap and done. Same start with len=41 → single error pulse; busy, done and key_out stay 0.
5. "T" with abort 6 cycles into the dash → key_out, tone_out and busy 0 on the next cycle; no done. A following start with "E" plays exactly as in test 1.
6. start re-pulsed with "M" mid-"E" → ignored, only "E" plays. rst_n low mid-mark → all outputs 0 asynchronously; after release, stays IDLE until a new start.
